pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazard types: load-use, taken branch/jump redirect from EX, and multi-cycle data-memory access in MEM. It also keeps a sticky memory-timeout flag and a stall-cycle performance counter.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipeline_hazard_ctrl_load_use.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard
//                controller: FSM state encoding and register-index width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

   // Width of an architectural register index (x0..x31)
   localparam int REG_W = 5;

   // Controller states
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_load_use_detect
//  Description : Combinational load-use comparator. Flags when the load in EX
//                writes a non-zero register that the instruction in ID reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_load_use_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] ifid_rs1,
   input  logic [REG_W-1:0] ifid_rs2,
   input  logic             ifid_use_rs1,
   input  logic             ifid_use_rs2,
   input  logic             idex_memRead,
   input  logic [REG_W-1:0] idex_rd,
   output logic             hit
);

   logic w_rs1_match;
   logic w_rs2_match;
   logic w_rd_nonzero;

   // x0 is hard-wired to zero, so a load targeting it never creates a hazard
   assign w_rd_nonzero = (idex_rd != '0);
   assign w_rs1_match  = ifid_use_rs1 && (ifid_rs1 == idex_rd);
   assign w_rs2_match  = ifid_use_rs2 && (ifid_rs2 == idex_rd);
   assign hit          = idex_memRead && w_rd_nonzero && (w_rs1_match || w_rs2_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Stall/flush sequencer for the 5-stage pipeline. Resolves
//                load-use, EX redirect and multi-cycle MEM hazards, keeps a
//                sticky memory-timeout flag and a saturating stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int STALL_CNT_W = 16
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REG_W-1:0]       ifid_rs1,
   input  logic [REG_W-1:0]       ifid_rs2,
   input  logic                   ifid_use_rs1,
   input  logic                   ifid_use_rs2,
   input  logic                   idex_memRead,
   input  logic [REG_W-1:0]       idex_rd,
   input  logic                   ex_redirect,
   input  logic                   exmem_memRead,
   input  logic                   exmem_memWrite,
   input  logic                   dmem_ready,
   output logic                   pc_write,
   output logic                   ifid_write,
   output logic                   ifid_flush,
   output logic                   idex_write,
   output logic                   idex_flush,
   output logic                   exmem_write,
   output logic                   memwb_bubble,
   output logic                   dmem_req,
   output logic                   mem_timeout,
   output logic [STALL_CNT_W-1:0] stall_count
);

   // Wide enough for the largest legal timeout (255)
   localparam int c_WAIT_W = 8;

   state_t                 r_state;
   logic [c_WAIT_W-1:0]    r_wait_cnt;
   logic                   r_mem_timeout;
   logic [STALL_CNT_W-1:0] r_stall_count;

   logic w_mem_access;
   logic w_load_use;
   logic w_mem_stall;

   hazard_load_use_detect u_load_use (
      .ifid_rs1     (ifid_rs1),
      .ifid_rs2     (ifid_rs2),
      .ifid_use_rs1 (ifid_use_rs1),
      .ifid_use_rs2 (ifid_use_rs2),
      .idex_memRead (idex_memRead),
      .idex_rd      (idex_rd),
      .hit          (w_load_use)
   );

   assign w_mem_access = exmem_memRead || exmem_memWrite;

   // In RUN only an incomplete access stalls; once waiting, anything short of
   // dmem_ready keeps the pipe frozen
   assign w_mem_stall = (r_state == MEM_WAIT) ? !dmem_ready
                                              : (w_mem_access && !dmem_ready);

   // Pipeline control decode from current state and hazard inputs; all zero in reset
   always_comb begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b0;
      idex_write   = 1'b0;
      idex_flush   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b0;
      dmem_req     = 1'b0;
      if (rst) begin
         case (r_state)
            RUN, MEM_WAIT: begin
               dmem_req = w_mem_access;
               if (w_mem_stall) begin
                  memwb_bubble = 1'b1;
               end else if (ex_redirect) begin
                  // ID instruction is squashed, so a coincident load-use is moot
                  pc_write    = 1'b1;
                  ifid_write  = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_write  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_write = 1'b1;
               end else if (w_load_use) begin
                  // Hold PC and IF/ID, inject a single bubble into EX
                  idex_write  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_write = 1'b1;
               end else begin
                  pc_write    = 1'b1;
                  ifid_write  = 1'b1;
                  idex_write  = 1'b1;
                  exmem_write = 1'b1;
               end
            end
            default: begin
               // ERR: frozen, downstream sees bubbles, no memory traffic
               memwb_bubble = 1'b1;
            end
         endcase
      end
   end

   // State machine, wait counter and sticky timeout flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= RUN;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_mem_stall) begin
                  r_state    <= MEM_WAIT;
                  r_wait_cnt <= c_WAIT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (dmem_ready) begin
                  r_state    <= RUN;
                  r_wait_cnt <= '0;
               end else if (r_wait_cnt == c_WAIT_W'(MEM_TIMEOUT)) begin
                  r_state       <= ERR;
                  r_mem_timeout <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
               end
            end
            ERR: begin
               r_state <= ERR;
            end
            default: begin
               r_state <= ERR;
            end
         endcase
      end
   end

   // Saturating count of cycles in which the PC was held
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_count <= '0;
      end else if (!pc_write && (r_stall_count != {STALL_CNT_W{1'b1}})) begin
         r_stall_count <= r_stall_count + STALL_CNT_W'(1);
      end
   end

   assign mem_timeout = r_mem_timeout;
   assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Self-checking bench for pipeline_hazard_ctrl: directed
//                scenarios plus randomized traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

   localparam int TO   = 3;
   localparam int SCW  = 6;
   localparam int SMAX = (1 << SCW) - 1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [4:0]     ifid_rs1, ifid_rs2, idex_rd;
   logic           ifid_use_rs1, ifid_use_rs2, idex_memRead, ex_redirect;
   logic           exmem_memRead, exmem_memWrite, dmem_ready;
   logic           pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
   logic           exmem_write, memwb_bubble, dmem_req, mem_timeout;
   logic [SCW-1:0] stall_count;
   logic [7:0]     ctrl;

   int tests_run    = 0;
   int tests_failed = 0;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .STALL_CNT_W(SCW)) dut (
      .clk(clk), .rst(rst_n),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
      .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
      .idex_memRead(idex_memRead), .idex_rd(idex_rd),
      .ex_redirect(ex_redirect),
      .exmem_memRead(exmem_memRead), .exmem_memWrite(exmem_memWrite),
      .dmem_ready(dmem_ready),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_flush(idex_flush),
      .exmem_write(exmem_write), .memwb_bubble(memwb_bubble),
      .dmem_req(dmem_req), .mem_timeout(mem_timeout), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // Control bundle: pc, ifid_w, ifid_f, idex_w, idex_f, exmem_w, bubble, req
   assign ctrl = {pc_write, ifid_write, ifid_flush, idex_write,
                  idex_flush, exmem_write, memwb_bubble, dmem_req};

   localparam logic [7:0] C_NORM   = 8'b1101_0100;
   localparam logic [7:0] C_LU     = 8'b0001_1100;
   localparam logic [7:0] C_REDIR  = 8'b1111_1100;
   localparam logic [7:0] C_FREEZE = 8'b0000_0010;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0;
      ifid_use_rs1 = 0; ifid_use_rs2 = 0; idex_memRead = 0; ex_redirect = 0;
      exmem_memRead = 0; exmem_memWrite = 0; dmem_ready = 0;
   endtask

   task automatic apply_reset();
      rst_n = 0;
      set_idle();
      tick();
      tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      set_idle();
      exmem_memRead = 1; ex_redirect = 1;
      #2;
      tests_run++;
      if (ctrl !== 8'h00 || stall_count !== '0 || mem_timeout !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: ctrl=%b stall=%0d to=%b, required 00000000/0/0",
                  ctrl, stall_count, mem_timeout);
      end
      tick();
      rst_n = 1;
      set_idle();
      #2;
      tests_run++;
      if (ctrl !== C_NORM) begin
         tests_failed++;
         $display("FAIL reset_release: ctrl=%b, required %b", ctrl, C_NORM);
      end
      tick();
   endtask

   task automatic test_load_use();
      apply_reset();
      idex_memRead = 1; idex_rd = 5; ifid_rs2 = 5; ifid_use_rs2 = 1;
      #2;
      tests_run++;
      if (ctrl !== C_LU) begin
         tests_failed++;
         $display("FAIL load_use_bubble: ctrl=%b, required %b", ctrl, C_LU);
      end
      tick();
      idex_memRead = 0;
      #2;
      tests_run++;
      if (ctrl !== C_NORM || stall_count !== 6'd1) begin
         tests_failed++;
         $display("FAIL load_use_after: ctrl=%b stall=%0d, required %b/1",
                  ctrl, stall_count, C_NORM);
      end
      tick();
   endtask

   task automatic test_redirect_load_use();
      apply_reset();
      idex_memRead = 1; idex_rd = 7; ifid_rs1 = 7; ifid_use_rs1 = 1; ex_redirect = 1;
      #2;
      tests_run++;
      if (ctrl !== C_REDIR) begin
         tests_failed++;
         $display("FAIL redirect_priority: ctrl=%b, required %b", ctrl, C_REDIR);
      end
      tick();
      set_idle();
      #2;
      tests_run++;
      if (stall_count !== 6'd0 || ctrl !== C_NORM) begin
         tests_failed++;
         $display("FAIL redirect_stall_count: stall=%0d ctrl=%b, required 0/%b",
                  stall_count, ctrl, C_NORM);
      end
      tick();
   endtask

   task automatic test_mem_wait();
      apply_reset();
      exmem_memRead = 1;
      for (int i = 0; i < 3; i++) begin
         #2;
         tests_run++;
         if (ctrl !== (C_FREEZE | 8'h01)) begin
            tests_failed++;
            $display("FAIL mem_wait_freeze[%0d]: ctrl=%b, required %b", i, ctrl, C_FREEZE | 8'h01);
         end
         tick();
      end
      dmem_ready = 1;
      #2;
      tests_run++;
      if (ctrl !== (C_NORM | 8'h01)) begin
         tests_failed++;
         $display("FAIL mem_wait_release: ctrl=%b, required %b", ctrl, C_NORM | 8'h01);
      end
      tick();
      set_idle();
      #2;
      tests_run++;
      if (stall_count !== 6'd3 || ctrl !== C_NORM || mem_timeout !== 1'b0) begin
         tests_failed++;
         $display("FAIL mem_wait_count: stall=%0d ctrl=%b to=%b, required 3/%b/0",
                  stall_count, ctrl, mem_timeout, C_NORM);
      end
      tick();
   endtask

   task automatic test_timeout();
      int bad;
      apply_reset();
      exmem_memWrite = 1;
      // one RUN stall cycle plus TO waiting cycles before ERR
      for (int i = 0; i < TO + 1; i++) begin
         #2;
         tests_run++;
         if (ctrl !== (C_FREEZE | 8'h01) || mem_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_wait[%0d]: ctrl=%b to=%b, required %b/0",
                     i, ctrl, mem_timeout, C_FREEZE | 8'h01);
         end
         tick();
      end
      bad = 0;
      for (int i = 0; i < 70; i++) begin
         dmem_ready   = 1'($urandom_range(0, 1));
         ex_redirect  = 1'($urandom_range(0, 1));
         exmem_memRead = 1'($urandom_range(0, 1));
         #2;
         if (ctrl !== C_FREEZE || mem_timeout !== 1'b1) bad++;
         tick();
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL timeout_err_frozen: %0d cycles off, required 0 (ctrl=%b to=%b)",
                  bad, ctrl, mem_timeout);
      end
      tests_run++;
      if (stall_count !== 6'(SMAX)) begin
         tests_failed++;
         $display("FAIL stall_saturate: stall=%0d, required %0d", stall_count, SMAX);
      end
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      exmem_memRead = 1;
      tick();
      tick();
      rst_n = 0;
      #1;
      tests_run++;
      if (ctrl !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_mid_wait_drop: ctrl=%b, required 00000000", ctrl);
      end
      tick();
      rst_n = 1;
      set_idle();
      #2;
      tests_run++;
      if (ctrl !== C_NORM || mem_timeout !== 1'b0 || stall_count !== 6'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_wait_recover: ctrl=%b to=%b stall=%0d, required %b/0/0",
                  ctrl, mem_timeout, stall_count, C_NORM);
      end
      tick();
   endtask

   task automatic test_x0_immunity();
      apply_reset();
      idex_memRead = 1; idex_rd = 0; ifid_rs1 = 0; ifid_use_rs1 = 1;
      ifid_rs2 = 0; ifid_use_rs2 = 1;
      #2;
      tests_run++;
      if (ctrl !== C_NORM) begin
         tests_failed++;
         $display("FAIL x0_immunity: ctrl=%b, required %b", ctrl, C_NORM);
      end
      tick();
   endtask

   // Reference model: freeze_run counts consecutive frozen cycles of one
   // memory access; exceeding TO of them means the access timed out.
   task automatic test_random();
      int        freeze_run, stalls, err_cycles, bad;
      bit        err;
      bit        mem, lu, frozen;
      logic [7:0] exp;
      apply_reset();
      freeze_run = 0; stalls = 0; err = 0; err_cycles = 0; bad = 0;
      for (int n = 0; n < 800; n++) begin
         if (err && err_cycles > 4) begin
            apply_reset();
            freeze_run = 0; stalls = 0; err = 0; err_cycles = 0;
         end
         ifid_rs1      = 5'($urandom_range(0, 3));
         ifid_rs2      = 5'($urandom_range(0, 3));
         idex_rd       = 5'($urandom_range(0, 3));
         ifid_use_rs1  = 1'($urandom_range(0, 1));
         ifid_use_rs2  = 1'($urandom_range(0, 1));
         idex_memRead  = 1'($urandom_range(0, 1));
         ex_redirect   = ($urandom_range(0, 4) == 0);
         exmem_memRead = ($urandom_range(0, 4) == 0);
         exmem_memWrite = ($urandom_range(0, 5) == 0);
         dmem_ready    = ($urandom_range(0, 9) < 6);
         #2;
         mem = exmem_memRead || exmem_memWrite;
         lu  = idex_memRead && (idex_rd != 0) &&
               ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
         frozen = !err && (freeze_run > 0 || mem) && !dmem_ready;
         if (err)              exp = C_FREEZE;
         else if (frozen)      exp = C_FREEZE | 8'(mem);
         else if (ex_redirect) exp = C_REDIR | 8'(mem);
         else if (lu)          exp = C_LU | 8'(mem);
         else                  exp = C_NORM | 8'(mem);
         tests_run++;
         if (ctrl !== exp || mem_timeout !== err || stall_count !== 6'(stalls)) begin
            tests_failed++;
            bad++;
            if (bad <= 10)
               $display("FAIL random[%0d]: ctrl=%b to=%b stall=%0d, required %b/%b/%0d",
                        n, ctrl, mem_timeout, stall_count, exp, err, stalls);
         end
         if (err) err_cycles++;
         else if (frozen) begin
            freeze_run++;
            if (freeze_run > TO) err = 1;
         end else freeze_run = 0;
         if (exp[7] == 1'b0 && stalls < SMAX) stalls++;
         tick();
      end
   endtask

   initial begin
      rst_n = 0;
      set_idle();
      #2;
      test_reset();
      test_load_use();
      test_redirect_load_use();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      test_x0_immunity();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
